// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule: sizes, FSM state type,
// round-key index type, S-box and round-constant helpers.
package aes_pkg;

    localparam int NB     = 128;
    localparam int WORD   = 32;
    localparam int NR     = 10;
    localparam int NUM_RK = NR + 1;
    localparam int NK     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    typedef logic [3:0] rk_idx_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input rk_idx_t r);
        logic [7:0] rc;
        case (r)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// One combinational AES-128 KeyExpansion step: round key N -> round key N+1.
// Keys are byte-packed with byte 0 in bits [7:0].
module aes_key_expansion
    import aes_pkg::*;
#(
    parameter int NB   = 128,
    parameter int WORD = 32,
    parameter int NK   = 4
) (
    input  logic [NB-1:0]   round_key,
    input  rk_idx_t         round_num,
    output logic [NB-1:0]   next_key
);

    logic [WORD-1:0] last_w;
    logic [WORD-1:0] rot_w;
    logic [WORD-1:0] sub_w;
    logic [WORD-1:0] prev_w;

    always_comb begin
        last_w = round_key[NB-1 -: WORD];
        // RotWord moves byte 0 to the top in little-byte packing
        rot_w  = {last_w[7:0], last_w[WORD-1:8]};
        sub_w  = '0;
        for (int b = 0; b < WORD/8; b++) begin
            sub_w[8*b +: 8] = sbox(rot_w[8*b +: 8]);
        end
        sub_w[7:0] = sub_w[7:0] ^ rcon(round_num);

        next_key = '0;
        prev_w   = sub_w;
        for (int j = 0; j < NK; j++) begin
            next_key[WORD*j +: WORD] = round_key[WORD*j +: WORD] ^ prev_w;
            prev_w                   = next_key[WORD*j +: WORD];
        end
    end

endmodule

// File: rtl/aes_key_scheduler.sv
// Sequential AES-128 key schedule with an 11-entry round-key store and registered read port.
// Optional AES_KS_ZEROIZE_EN adds a zeroize input and a resettable, wipeable store.
//
// state  | meaning
// IDLE   | no keys held, waiting for a key handshake
// EXPAND | one round key generated and stored per cycle
// DONE   | all 11 round keys stored, keys_valid high, new key accepted
module aes_key_scheduler
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NB-1:0]   key_in,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            busy,
    output logic            keys_valid,
    input  rk_idx_t         rd_idx,
`ifdef AES_KS_ZEROIZE_EN
    input  logic            zeroize,
`endif
    output logic [NB-1:0]   rd_key
);

    ks_state_t       state_q, state_d;
    rk_idx_t         cnt_q, cnt_d;
    logic [NB-1:0]   work_q, work_d;
    logic [NB-1:0]   rd_key_q, rd_key_d;
    logic [NB-1:0]   exp_key;
    logic [NB-1:0]   store_q [NUM_RK];
    logic            wr_en;
    rk_idx_t         wr_idx;
    logic [NB-1:0]   wr_data;
    logic            load;
    logic            zero_req;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign load = key_valid && key_ready;

    aes_key_expansion #(
        .NB   (NB),
        .WORD (WORD),
        .NK   (NK)
    ) u_key_expansion (
        .round_key (work_q),
        .round_num (cnt_q),
        .next_key  (exp_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (load) state_d = EXPAND;
            EXPAND:     if (cnt_q == rk_idx_t'(NR - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (zero_req) state_d = IDLE;
    end

    always_comb begin
        key_ready  = (state_q != EXPAND);
        busy       = (state_q == EXPAND);
        keys_valid = (state_q == DONE);
    end

    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = exp_key;
        if (zero_req) begin
            work_d = '0;
            cnt_d  = '0;
        end else if (state_q == EXPAND) begin
            work_d = exp_key;
            wr_en  = 1'b1;
            wr_idx = cnt_q + 4'd1;
            // Counter parks at the last round number instead of wrapping
            if (cnt_q != rk_idx_t'(NR - 1)) cnt_d = cnt_q + 4'd1;
        end else if (load) begin
            work_d  = key_in;
            cnt_d   = '0;
            wr_en   = 1'b1;
            wr_data = key_in;
        end
    end

    always_comb begin
        rd_key_d = '0;
        if (!zero_req && rd_idx <= rk_idx_t'(NR)) rd_key_d = store_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            work_q   <= '0;
            rd_key_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            rd_key_q <= rd_key_d;
        end
    end

`ifdef AES_KS_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RK; i++) store_q[i] <= '0;
        end else if (zero_req) begin
            for (int i = 0; i < NUM_RK; i++) store_q[i] <= '0;
        end else if (wr_en) begin
            store_q[wr_idx] <= wr_data;
        end
    end
`else
    // No reset so the store can map onto plain flops or RAM
    always_ff @(posedge clk) begin
        if (wr_en) store_q[wr_idx] <= wr_data;
    end
`endif

    assign rd_key = rd_key_q;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler; reference schedule built from
// FIPS-197 word arithmetic with an S-box derived from GF(2^8) inversion.
module tb_aes_key_scheduler;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk   [11];

    aes_key_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 expansion on big-endian words, repacked to byte 0 in [7:0]
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++)
            w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            for (int b = 0; b < 16; b++)
                exp_rk[r][8*b +: 8] = w[4*r + b/4][31 - 8*(b%4) -: 8];
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts edges until keys_valid
    task automatic wait_keys_valid(output int cyc);
        cyc = 0;
        while (!keys_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic read_key(input int idx, output logic [127:0] val);
        @(negedge clk);
        rd_idx = 4'(idx);
        @(posedge clk);
        #1;
        val = rd_key;
    endtask

    task automatic check_store(input string tag);
        logic [127:0] v;
        for (int i = 0; i < 11; i++) begin
            read_key(i, v);
            check($sformatf("%s_rk%0d", tag, i), v, exp_rk[i]);
        end
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] key_a, key_b;
        int           cyc;
        logic         seen;

        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        rd_idx    = '0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        build_sbox();
        #13;
        check("rst_key_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_keys_valid", keys_valid, 0);
        check("rst_rd_key", rd_key, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vector
        key_a = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
        compute_model(key_a);
        load_key(key_a);
        check("fips_busy", busy, 1);
        check("fips_key_ready", key_ready, 0);
        wait_keys_valid(cyc);
        check("fips_latency", 128'(cyc), 10);
        read_key(1, v);
        check("fips_rk1", v, 128'h05766c2a_3939a323_b12c5488_17fefaa0);
        read_key(10, v);
        check("fips_rk10", v, 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0);
        read_key(0, v);
        check("fips_rk0", v, key_a);
        check_store("fips");
        for (int i = 11; i < 16; i++) begin
            read_key(i, v);
            check($sformatf("oob_idx%0d", i), v, 0);
        end

        // key_valid held through EXPAND with a different key
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        compute_model(key_a);
        @(negedge clk);
        key_in    = key_a;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_in = key_b;
        seen   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (key_ready !== 1'b0 || busy !== 1'b1) seen = 1'b1;
            if (k == 9) key_valid = 1'b0;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("hold_key_ready_low", 128'(seen), 0);
        @(posedge clk);
        #1;
        check("hold_keys_valid", keys_valid, 1);
        check_store("hold");

        // Reload in DONE with the all-zero key
        compute_model('0);
        load_key('0);
        check("reload_drop", keys_valid, 0);
        wait_keys_valid(cyc);
        check("reload_latency", 128'(cyc), 10);
        read_key(10, v);
        check("zero_rk10", v, 128'h8e188f6f_cf51e923_11e2923e_cb5befb4);
        check_store("zero");

        // Asynchronous reset during EXPAND
        key_a = {$urandom, $urandom, $urandom, $urandom};
        rd_idx = 4'd0;
        load_key(key_a);
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_key_ready", key_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_keys_valid", keys_valid, 0);
        check("arst_rd_key", rd_key, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (keys_valid !== 1'b0) seen = 1'b1;
        end
        check("post_rst_no_valid", 128'(seen), 0);

        // Several random keys, full schedule each
        for (int n = 0; n < 3; n++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            compute_model(key_a);
            load_key(key_a);
            wait_keys_valid(cyc);
            check($sformatf("rand%0d_latency", n), 128'(cyc), 10);
            check_store($sformatf("rand%0d", n));
        end

`ifdef AES_KS_ZEROIZE_EN
        // Zeroize beats a same-cycle handshake in DONE
        @(negedge clk);
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        zeroize   = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        zeroize   = 1'b0;
        check("zz_keys_valid", keys_valid, 0);
        check("zz_key_ready", key_ready, 1);
        check("zz_busy", busy, 0);
        check("zz_rd_key", rd_key, 0);
        repeat (3) @(posedge clk);
        #1;
        check("zz_idle_busy", busy, 0);
        check("zz_idle_keys_valid", keys_valid, 0);
        for (int i = 0; i < 11; i++) exp_rk[i] = '0;
        check_store("zz");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
